// File: rtl/arb_pkg.sv
// Shared definitions for the round-robin mux arbiter: requester count,
// select width, FSM state encoding and one-hot/encode helpers.
package arb_pkg;

  localparam int NREQ = 4;
  localparam int SELW = 2;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_e;

  // Index to one-hot grant vector.
  function automatic logic [NREQ-1:0] onehot(input logic [SELW-1:0] idx);
    logic [NREQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  // One-hot grant vector back to index (lowest set bit wins if malformed).
  function automatic logic [SELW-1:0] encode(input logic [NREQ-1:0] oh);
    logic [SELW-1:0] v;
    v = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (oh[i]) v = SELW'(i);
    end
    return v;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational rotate-priority picker. Scans req starting at index
// 'start' and wrapping; when mask_start is set the start index itself is
// skipped, so the scan covers only the other three requesters.
module rr_pick
  import arb_pkg::*;
(
  input  logic [NREQ-1:0] req,
  input  logic [SELW-1:0] start,
  input  logic            mask_start,
  output logic            found,
  output logic [SELW-1:0] idx
);

  logic [SELW-1:0] cand;

  // Walk offsets from farthest to nearest so the nearest hit is the one kept.
  always_comb begin
    found = 1'b0;
    idx   = start;
    cand  = start;
    for (int k = NREQ - 1; k >= 0; k--) begin
      cand = start + SELW'(k);
      if (req[cand] && !(k == 0 && mask_start)) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter driving a shared 4:1 byte mux. Grants are one-hot and
// registered, each owner is limited to MAX_HOLD consecutive grant cycles,
// and transferred bytes appear on dout one cycle after each beat.
// Optional build macro: ARB_PRIO0_EN makes requester 0 urgent (preempts any
// other owner and holds the grant without limit while it requests).
// Handshake: a beat is any cycle where gnt[i] & req[i]; the byte from din_i
// is registered on dout with dvalid high at the following edge. There is no
// back-pressure from the consumer. busy reflects the full FSM state.
module rr_mux_arbiter #(
  parameter int DW       = 8,
  parameter int MAX_HOLD = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [3:0]    req,
  input  logic [DW-1:0] din0,
  input  logic [DW-1:0] din1,
  input  logic [DW-1:0] din2,
  input  logic [DW-1:0] din3,
  output logic [3:0]    gnt,
  output logic [1:0]    sel,
  output logic          en,
  output logic [DW-1:0] dout,
  output logic          dvalid,
  output logic          busy
);
  import arb_pkg::*;

  localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

  arb_state_e      state;
  logic [SELW-1:0] last;
  logic [HW-1:0]   hold_cnt;

  logic [SELW-1:0] pick_start;
  logic            pick_mask;
  logic            pick_found;
  logic [SELW-1:0] pick_idx;

  logic [DW-1:0]   din_sel;
  logic            beat;

  logic            grant_new;
  logic [SELW-1:0] grant_idx;
  logic            hold_inc;
  logic            hold_clr;
  logic            go_idle;

  // Idle scans from the requester after the last owner; in GRANT the current
  // owner is skipped so any other pending requester is found first.
  always_comb begin
    if (state == ST_IDLE) begin
      pick_start = last + SELW'(1);
      pick_mask  = 1'b0;
    end else begin
      pick_start = sel;
      pick_mask  = 1'b1;
    end
  end

  rr_pick u_pick (
    .req        (req),
    .start      (pick_start),
    .mask_start (pick_mask),
    .found      (pick_found),
    .idx        (pick_idx)
  );

  // The shared 4:1 byte mux steered by the registered select.
  always_comb begin
    case (sel)
      2'd0:    din_sel = din0;
      2'd1:    din_sel = din1;
      2'd2:    din_sel = din2;
      default: din_sel = din3;
    endcase
  end

  assign beat = |(gnt & req);

  // Grant decision for the coming edge.
  always_comb begin
    grant_new = 1'b0;
    grant_idx = pick_idx;
    hold_inc  = 1'b0;
    hold_clr  = 1'b0;
    go_idle   = 1'b0;
    if (state == ST_IDLE) begin
      grant_new = pick_found;
`ifdef ARB_PRIO0_EN
      if (req[0]) begin
        grant_new = 1'b1;
        grant_idx = '0;
      end
`endif
    end else begin
`ifdef ARB_PRIO0_EN
      if (req[0] && sel != '0) begin
        grant_new = 1'b1;
        grant_idx = '0;
      end else if (req[0]) begin
        hold_inc = 1'b1;
      end else
`endif
      if (req[sel] && hold_cnt < HOLD_LAST) begin
        hold_inc = 1'b1;
      end else if (pick_found) begin
        grant_new = 1'b1;
      end else if (req[sel]) begin
        hold_clr = 1'b1;
      end else begin
        go_idle = 1'b1;
      end
    end
  end

  // FSM, grant registers, hold counter and output byte register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      gnt      <= '0;
      sel      <= '0;
      en       <= 1'b0;
      dout     <= '0;
      dvalid   <= 1'b0;
      last     <= SELW'(NREQ - 1);
      hold_cnt <= '0;
    end else begin
      dvalid <= beat;
      if (beat) dout <= din_sel;
      if (grant_new) begin
        state    <= ST_GRANT;
        gnt      <= onehot(grant_idx);
        sel      <= grant_idx;
        en       <= 1'b1;
        last     <= grant_idx;
        hold_cnt <= '0;
      end else if (hold_inc) begin
        if (hold_cnt < HOLD_LAST) hold_cnt <= hold_cnt + HW'(1);
      end else if (hold_clr) begin
        hold_cnt <= '0;
      end else if (go_idle) begin
        state    <= ST_IDLE;
        gnt      <= '0;
        sel      <= '0;
        en       <= 1'b0;
        hold_cnt <= '0;
      end
    end
  end

  assign busy = (state == ST_GRANT);

endmodule

// File: doc/rr_mux_arbiter.md
Name: rr_mux_arbiter

Overview:
- Round-robin arbiter sharing one 4:1 byte-wide mux datapath (mux41_8b-style select/enable) among 4 requesters.
- Generates one-hot grants, the 2-bit mux select and enable, and a registered output byte with a valid flag.
- Enforces a bounded hold per requester so no single requester can starve the others.
- Sits between requester blocks and the downstream byte consumer.

Parameters:
- DW, 8, data width per requester and of dout.
- MAX_HOLD, 4, maximum consecutive granted cycles per requester before forced rotation (>=1).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- req  input  4  request per requester; held high while the requester has data.
- din0  input  DW  requester 0 data.
- din1  input  DW  requester 1 data.
- din2  input  DW  requester 2 data.
- din3  input  DW  requester 3 data.
- gnt  output  4  one-hot grant, registered.
- sel  output  2  mux select = encoded gnt, registered.
- en  output  1  mux enable = |gnt.
- dout  output  DW  registered transferred byte.
- dvalid  output  1  dout valid this cycle.
- busy  output  1  FSM in GRANT.

Behaviour:
- Reset (async, rst=1): state=IDLE, gnt=0, sel=0, en=0, dout=0, dvalid=0, busy=0, last=3 (so requester 0 wins first), hold_cnt=0.
- FSM states: IDLE, GRANT.
- IDLE:
  - If req!=0, pick the first set bit scanning last+1, last+2, ... mod 4.
  - Next edge: gnt=onehot(winner), sel=winner, state=GRANT, hold_cnt=0, last=winner.
  - If req==0, remain in IDLE.
- Transfer: a cycle with gnt[i]&req[i]=1 is a beat. At the next edge dout<=din_i (via sel) and dvalid<=1; otherwise dvalid<=0 and dout holds. Latency: req rise to first dvalid = 2 cycles from IDLE.
- GRANT, owner o, evaluated each cycle:
  - req[o]=1 and hold_cnt<MAX_HOLD-1: keep grant, hold_cnt++.
  - req[o]=0 or hold_cnt==MAX_HOLD-1: re-arbitrate in the same cycle among req with o excluded first, scanning from o+1.
    - Another requester pending: switch gnt at the next edge, no idle bubble; hold_cnt=0; last=new owner.
    - No other requester, req[o]=1: keep o, hold_cnt=0.
    - No requester at all: gnt=0, state=IDLE.
- A requester dropping req while granted loses that cycle's beat (no dvalid). Grant changes only at clock edges.
- hold_cnt width = clog2(MAX_HOLD), saturates and never wraps past MAX_HOLD-1.
- Simultaneous requests: rotating priority only; equal requesters are served fairly within 3 grants.
- Reset mid-burst: all outputs clear immediately (async). The in-flight beat is lost.

Optional Feature:
- ARB_PRIO0_EN.
- Defined: requester 0 is urgent.
  - If req[0]=1 while another owner holds the grant, the grant moves to 0 at the next edge regardless of hold_cnt.
  - Requester 0 keeps the grant while req[0]=1, with no hold limit.
  - On release, rotation resumes from last=0.
- Undefined: pure round-robin as above.

Decomposition:
- Shared package/include arb_pkg:
  - NREQ=4.
  - SELW=2.
  - State encodings ST_IDLE=1'b0, ST_GRANT=1'b1.
  - onehot/encode helper functions.
- One sub-module: rr_pick.
  - Combinational rotate-priority picker.
  - Inputs: req[3:0], start[1:0], mask_start.
  - Outputs: found, idx[1:0].
  - Instantiated once; all registers live in the top.

Test Plan:
- Reset then req=4'b0001, din0=8'hA5 held: gnt=0001 at cycle 1, dout=A5/dvalid=1 from cycle 2, 4 beats, then re-grant to 0 (no contender), dvalid continuous.
- req=4'b1111 constant, din_i=8'h10+i, MAX_HOLD=4: dout sequence 10x4, 11x4, 12x4, 13x4, 10x4; no dvalid gap at handovers.
- Owner 2 drops req after 2 beats with req[3]=1: gnt 0100 -> 1000 at the next edge, hold_cnt restarts, dout shows 2 bytes from din2 then din3.
- All req drop during GRANT: gnt=0, en=0, busy=0 next edge; dvalid low after the last beat; state returns to IDLE.
- Assert rst mid-burst (between edges): gnt, sel, dout, dvalid clear immediately. After release with req=4'b0110, requester 1 is granted first.
- ARB_PRIO0_EN defined, owner 3 at hold_cnt=1, req[0] rises: gnt=0001 next edge; held 10 cycles past MAX_HOLD; after req[0] drops, requester 1 is served before 3.
